// File: rtl/mult_div_unit_if.sv
// Handshake/bus bundle between the E-stage pipeline and the multiply/divide unit.
// master = pipeline side (drives requests/operands), slave = the unit itself.
interface mult_div_unit_if;
   logic        Req;
   logic        MDU_Start;
   logic [2:0]  MDU_Op;
   logic        MDU_HI_Write;
   logic        MDU_LO_Write;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Req, MDU_Start, MDU_Op, MDU_HI_Write, MDU_LO_Write, A, B,
      input  Busy, HI, LO
   );

   modport slave (
      input  Req, MDU_Start, MDU_Op, MDU_HI_Write, MDU_LO_Write, A, B,
      output Busy, HI, LO
   );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit with fixed 5/10-cycle latency.
// Optional macro MDU_DIVZERO_KEEP_EN: divide by zero leaves HI/LO untouched.
module mult_div_unit (
   input logic             clk,
   input logic             reset,
   mult_div_unit_if.slave  bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;
   logic [31:0] shadow_hi_reg, shadow_hi_next;
   logic [31:0] shadow_lo_reg, shadow_lo_next;
   logic        skip_reg, skip_next;

   logic [63:0] a_sx, b_sx, prod_s, prod_u;
   logic        a_neg, b_neg, op_valid, is_div, div_zero, start_ok;
   logic [31:0] a_mag, b_mag, div_s, div_u;
   logic [31:0] sq, sr, q_s, r_s, uq, ur;

   // Result datapath; divisors are forced non-zero so no X ever escapes.
   always_comb begin
      a_sx   = {{32{bus.A[31]}}, bus.A};
      b_sx   = {{32{bus.B[31]}}, bus.B};
      prod_s = a_sx * b_sx;
      prod_u = {32'd0, bus.A} * {32'd0, bus.B};

      a_neg  = bus.A[31];
      b_neg  = bus.B[31];
      a_mag  = a_neg ? (32'd0 - bus.A) : bus.A;
      b_mag  = b_neg ? (32'd0 - bus.B) : bus.B;
      div_s  = (b_mag == 32'd0) ? 32'd1 : b_mag;
      div_u  = (bus.B == 32'd0) ? 32'd1 : bus.B;

      // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps).
      sq  = a_mag / div_s;
      sr  = a_mag % div_s;
      q_s = (a_neg ^ b_neg) ? (32'd0 - sq) : sq;
      r_s = a_neg ? (32'd0 - sr) : sr;
      uq  = bus.A / div_u;
      ur  = bus.A % div_u;
   end

   assign op_valid = ~bus.MDU_Op[2];
   assign is_div   = bus.MDU_Op[1];
   assign div_zero = is_div & (bus.B == 32'd0);
   assign start_ok = (state_reg == IDLE) & bus.MDU_Start & ~bus.Req & op_valid;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      hi_next        = hi_reg;
      lo_next        = lo_reg;
      shadow_hi_next = shadow_hi_reg;
      shadow_lo_next = shadow_lo_reg;
      skip_next      = skip_reg;

      case (state_reg)
         IDLE: begin
            if (start_ok) begin
               state_next = RUN;
               cnt_next   = is_div ? 4'd10 : 4'd5;
               skip_next  = 1'b0;
               case (bus.MDU_Op[1:0])
                  2'd0:    {shadow_hi_next, shadow_lo_next} = prod_s;
                  2'd1:    {shadow_hi_next, shadow_lo_next} = prod_u;
                  2'd2:    {shadow_hi_next, shadow_lo_next} = {r_s, q_s};
                  default: {shadow_hi_next, shadow_lo_next} = {ur, uq};
               endcase
               if (div_zero) begin
`ifdef MDU_DIVZERO_KEEP_EN
                  skip_next = 1'b1;
`else
                  shadow_hi_next = bus.A;
                  shadow_lo_next = 32'hFFFF_FFFF;
`endif
               end
            end else if (!bus.Req) begin
               if (bus.MDU_HI_Write) hi_next = bus.A;
               if (bus.MDU_LO_Write) lo_next = bus.A;
            end
         end
         RUN: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1) begin
               cnt_next   = 4'd0;
               state_next = IDLE;
               if (!skip_reg) begin
                  hi_next = shadow_hi_reg;
                  lo_next = shadow_lo_reg;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         hi_reg        <= 32'd0;
         lo_reg        <= 32'd0;
         shadow_hi_reg <= 32'd0;
         shadow_lo_reg <= 32'd0;
         skip_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         hi_reg        <= hi_next;
         lo_reg        <= lo_next;
         shadow_hi_reg <= shadow_hi_next;
         shadow_lo_reg <= shadow_lo_next;
         skip_reg      <= skip_next;
      end
   end

   assign bus.Busy = (state_reg == RUN);
   assign bus.HI   = hi_reg;
   assign bus.LO   = lo_reg;
endmodule
